// File: rtl/flit_credit_tx_pkg.sv
// Shared NoC definitions for the credit-based flit transmitter: the packet
// state encoding and the credit-counter width helper.
package flit_credit_tx_pkg;

  // Packet framing state: IDLE between packets, BODY after a head went out
  // without its tail.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BODY = 1'b1
  } pkt_state_e;

  // Width needed to hold a credit count from 0 up to and including depth.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int CREDIT_DEPTH_DEFAULT = 4;
  localparam int CREDIT_W_DEFAULT     = credit_width(CREDIT_DEPTH_DEFAULT);

endpackage

// File: rtl/flit_fifo.sv
// Small synchronous FIFO for packed flits. A push and a pop can happen in the
// same cycle, including when full (the pop frees the slot). A pop on an empty
// FIFO is ignored.
module flit_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] ZERO_PTR  = {PTR_W{1'b0}};
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ZERO_CNT  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? ZERO_PTR : ptr + PTR_W'(1);
  endfunction

  // Qualify the raw requests against the current occupancy.
  always_comb begin
    do_pop_s  = pop && (count_r != ZERO_CNT);
    do_push_s = push && ((count_r != DEPTH_CNT) || do_pop_s);
  end

  // Read/write pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= ZERO_PTR;
      rd_ptr_r <= ZERO_PTR;
      count_r  <= ZERO_CNT;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= next_ptr(wr_ptr_r);
      end
      if (do_pop_s) begin
        rd_ptr_r <= next_ptr(rd_ptr_r);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + ONE_CNT;
        2'b01:   count_r <= count_r - ONE_CNT;
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_ptr_r];
  assign full    = (count_r == DEPTH_CNT);
  assign empty   = (count_r == ZERO_CNT);

endmodule

// File: rtl/flit_credit_tx.sv
// Credit-based flit transmitter: buffers flits locally and launches one onto
// the link whenever a flit is waiting and the downstream router has a free
// slot. Credits return one at a time via credit_in.
module flit_credit_tx
  import flit_credit_tx_pkg::*;
#(
  parameter int FLIT_WIDTH      = 32,
  parameter int DEST_WIDTH      = 4,
  parameter int CREDIT_DEPTH    = 4,
  parameter int IN_BUFFER_DEPTH = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [FLIT_WIDTH-1:0]                 in_data,
  input  logic [DEST_WIDTH-1:0]                 in_dest,
  input  logic                                  in_is_tail,
  output logic [FLIT_WIDTH-1:0]                 data_out,
  output logic [DEST_WIDTH-1:0]                 dest_out,
  output logic                                  is_tail_out,
  output logic                                  send_out,
  input  logic                                  credit_in,
  output logic [credit_width(CREDIT_DEPTH)-1:0] credit_count,
  output logic                                  pkt_active,
  output logic                                  credit_error
);

  localparam int CW     = credit_width(CREDIT_DEPTH);
  localparam int FIFO_W = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam logic [CW-1:0] CREDIT_FULL = CW'(CREDIT_DEPTH);
  localparam logic [CW-1:0] CREDIT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CREDIT_ONE  = CW'(1);

  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [FIFO_W-1:0]     fifo_rd_s;
  logic                  push_s;
  logic                  send_ok_s;
  logic [FLIT_WIDTH-1:0] head_data_s;
  logic [DEST_WIDTH-1:0] head_dest_s;
  logic                  head_tail_s;

  logic [CW-1:0]         credit_r;
  logic                  credit_err_r;
  logic [FLIT_WIDTH-1:0] data_r;
  logic [DEST_WIDTH-1:0] dest_r;
  logic                  tail_r;
  logic                  send_r;
  pkt_state_e            state_r;
  pkt_state_e            state_next_s;
  logic                  pkt_active_s;

  // Accept and launch conditions. Credits come only from the register, so a
  // returning credit is usable the cycle after it arrives.
  always_comb begin
    push_s    = in_valid && !fifo_full_s;
    send_ok_s = !fifo_empty_s && (credit_r != CREDIT_ZERO);
  end

  assign {head_data_s, head_dest_s, head_tail_s} = fifo_rd_s;

  flit_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (IN_BUFFER_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_s),
    .wr_data ({in_data, in_dest, in_is_tail}),
    .pop     (send_ok_s),
    .rd_data (fifo_rd_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Link output registers: load the popped head and pulse send for one cycle;
  // payload fields hold between sends.
  always_ff @(posedge clk) begin
    if (rst) begin
      send_r <= 1'b0;
      data_r <= {FLIT_WIDTH{1'b0}};
      dest_r <= {DEST_WIDTH{1'b0}};
      tail_r <= 1'b0;
    end else begin
      send_r <= send_ok_s;
      if (send_ok_s) begin
        data_r <= head_data_s;
        dest_r <= head_dest_s;
        tail_r <= head_tail_s;
      end
    end
  end

  // Credit counter: a send consumes, a returned credit restores, both cancel.
  // A credit returned while already full saturates and flags a sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit_r     <= CREDIT_FULL;
      credit_err_r <= 1'b0;
    end else begin
      case ({send_ok_s, credit_in})
        2'b10: credit_r <= credit_r - CREDIT_ONE;
        2'b01: begin
          if (credit_r == CREDIT_FULL) begin
            credit_err_r <= 1'b1;
          end else begin
            credit_r <= credit_r + CREDIT_ONE;
          end
        end
        default: credit_r <= credit_r;
      endcase
    end
  end

  // Packet FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Packet FSM next state: advanced only by a flit leaving on the link.
  always_comb begin
    state_next_s = state_r;
    if (send_ok_s) begin
      case (state_r)
        IDLE:    state_next_s = head_tail_s ? IDLE : BODY;
        BODY:    state_next_s = head_tail_s ? IDLE : BODY;
        default: state_next_s = IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Packet FSM outputs: a packet is open exactly while in BODY.
  always_comb begin
    pkt_active_s = 1'b0;
    case (state_r)
      BODY:    pkt_active_s = 1'b1;
      IDLE:    pkt_active_s = 1'b0;
      default: pkt_active_s = 1'b0;
    endcase
  end

  assign in_ready     = !fifo_full_s;
  assign data_out     = data_r;
  assign dest_out     = dest_r;
  assign is_tail_out  = tail_r;
  assign send_out     = send_r;
  assign credit_count = credit_r;
  assign credit_error = credit_err_r;
  assign pkt_active   = pkt_active_s;

endmodule

// File: tb/tb_flit_credit_tx.sv
// Scoreboard bench for flit_credit_tx: stimulus pushes expected flits into a
// queue, a negedge monitor pops and compares every link send.
module tb_flit_credit_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_dest;
  logic        in_is_tail;
  logic [31:0] data_out;
  logic [3:0]  dest_out;
  logic        is_tail_out;
  logic        send_out;
  logic        credit_in;
  logic [2:0]  credit_count;
  logic        pkt_active;
  logic        credit_error;

  int n_cmp = 0;
  int n_err = 0;
  int sent_cnt = 0;
  int base;
  logic [36:0] exp_q [$];

  flit_credit_tx #(
    .FLIT_WIDTH(32), .DEST_WIDTH(4), .CREDIT_DEPTH(4), .IN_BUFFER_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dest(in_dest), .in_is_tail(in_is_tail),
    .data_out(data_out), .dest_out(dest_out), .is_tail_out(is_tail_out),
    .send_out(send_out), .credit_in(credit_in), .credit_count(credit_count),
    .pkt_active(pkt_active), .credit_error(credit_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: every link send must match the oldest outstanding expected flit.
  always @(negedge clk) begin
    if (send_out === 1'b1) begin
      sent_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_send: got %0h expected none (t=%0t)",
                 {data_out, dest_out, is_tail_out}, $time);
      end else begin
        chk("flit", {27'd0, data_out, dest_out, is_tail_out}, {27'd0, exp_q.pop_front()});
      end
    end
  end

  // Present a flit now (caller knows in_ready is 1) and record it as expected.
  task automatic drive(input logic [31:0] d, input logic [3:0] dst, input logic t);
    in_valid = 1'b1; in_data = d; in_dest = dst; in_is_tail = t;
    exp_q.push_back({d, dst, t});
  endtask

  // Present a flit, wait (bounded) for acceptance, return one tick after it.
  task automatic push_flit(input logic [31:0] d, input logic [3:0] dst, input logic t);
    int w = 0;
    in_valid = 1'b1; in_data = d; in_dest = dst; in_is_tail = t;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
    end else begin
      exp_q.push_back({d, dst, t});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1; in_valid = 1'b0; credit_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_dest = 4'd0;
    in_is_tail = 1'b0; credit_in = 1'b1;
    // Reset with credit_in held high: the credit must be ignored.
    tick(3);
    credit_in = 1'b0;
    rst = 1'b0;
    chk("rst_credit_count", {61'd0, credit_count}, 64'd4);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_send_out", {63'd0, send_out}, 64'd0);
    chk("rst_pkt_active", {63'd0, pkt_active}, 64'd0);
    chk("rst_credit_error", {63'd0, credit_error}, 64'd0);
    chk("rst_data_out", {32'd0, data_out}, 64'd0);

    // Three-flit packet to dest 5, tail on flit 3, no credits returned.
    drive(32'hA000_0001, 4'h5, 1'b0); tick(1);
    chk("p3_c1_send", {63'd0, send_out}, 64'd0);
    chk("p3_c1_active", {63'd0, pkt_active}, 64'd0);
    drive(32'hA000_0002, 4'h5, 1'b0); tick(1);
    chk("p3_c2_send", {63'd0, send_out}, 64'd1);
    chk("p3_c2_active", {63'd0, pkt_active}, 64'd1);
    chk("p3_c2_credit", {61'd0, credit_count}, 64'd3);
    drive(32'hA000_0003, 4'h5, 1'b1); tick(1);
    in_valid = 1'b0;
    chk("p3_c3_send", {63'd0, send_out}, 64'd1);
    chk("p3_c3_active", {63'd0, pkt_active}, 64'd1);
    chk("p3_c3_credit", {61'd0, credit_count}, 64'd2);
    tick(1);
    chk("p3_c4_send", {63'd0, send_out}, 64'd1);
    chk("p3_c4_active", {63'd0, pkt_active}, 64'd0);
    chk("p3_c4_credit", {61'd0, credit_count}, 64'd1);
    tick(1);
    chk("p3_c5_send", {63'd0, send_out}, 64'd0);
    chk("p3_c5_credit", {61'd0, credit_count}, 64'd1);
    chk("p3_hold_data", {32'd0, data_out}, 64'hA000_0003);
    chk("p3_hold_tail", {63'd0, is_tail_out}, 64'd1);

    // Credit return and send in the same cycle at count 2.
    reset_dut();
    push_flit(32'hB000_0001, 4'h2, 1'b1);
    push_flit(32'hB000_0002, 4'h2, 1'b1);
    tick(3);
    chk("both_pre_credit", {61'd0, credit_count}, 64'd2);
    drive(32'hB000_0003, 4'h3, 1'b1); tick(1);
    in_valid = 1'b0; credit_in = 1'b1;
    tick(1);
    credit_in = 1'b0;
    chk("both_send", {63'd0, send_out}, 64'd1);
    chk("both_credit", {61'd0, credit_count}, 64'd2);
    chk("both_no_error", {63'd0, credit_error}, 64'd0);

    // Credit overflow at full count saturates and sets the sticky error.
    reset_dut();
    credit_in = 1'b1; tick(1); credit_in = 1'b0;
    chk("ovf_credit", {61'd0, credit_count}, 64'd4);
    chk("ovf_error", {63'd0, credit_error}, 64'd1);
    push_flit(32'hC000_0001, 4'h7, 1'b1);
    tick(3);
    chk("ovf_error_sticky", {63'd0, credit_error}, 64'd1);
    chk("ovf_after_send", {61'd0, credit_count}, 64'd3);
    reset_dut();
    chk("ovf_error_cleared", {63'd0, credit_error}, 64'd0);

    // Stream six flits with no credits: four go out, the FIFO fills.
    base = sent_cnt;
    push_flit(32'hD000_0001, 4'h1, 1'b0);
    push_flit(32'hD000_0002, 4'h1, 1'b0);
    push_flit(32'hD000_0003, 4'h1, 1'b1);
    push_flit(32'hD000_0004, 4'h9, 1'b0);
    push_flit(32'hD000_0005, 4'h9, 1'b0);
    push_flit(32'hD000_0006, 4'h9, 1'b1);
    chk("strm_in_ready_low", {63'd0, in_ready}, 64'd0);
    chk("strm_credit_zero", {61'd0, credit_count}, 64'd0);
    tick(3);
    chk("strm_sent4", 64'(sent_cnt - base), 64'd4);
    chk("strm_idle_send", {63'd0, send_out}, 64'd0);
    chk("strm_active", {63'd0, pkt_active}, 64'd1);
    credit_in = 1'b1; tick(1); credit_in = 1'b0;
    chk("strm_credit_back", {61'd0, credit_count}, 64'd1);
    chk("strm_not_yet", {63'd0, send_out}, 64'd0);
    tick(1);
    chk("strm_flit5_send", {63'd0, send_out}, 64'd1);
    chk("strm_credit_again0", {61'd0, credit_count}, 64'd0);
    chk("strm_in_ready_back", {63'd0, in_ready}, 64'd1);
    chk("strm_flit5_data", {32'd0, data_out}, 64'hD000_0005);

    // Reset in the middle of a four-flit packet after flit 2.
    reset_dut();
    base = sent_cnt;
    drive(32'hE000_0001, 4'h4, 1'b0); tick(1);
    drive(32'hE000_0002, 4'h4, 1'b0); tick(1);
    in_valid = 1'b1; in_data = 32'hE000_0003; in_is_tail = 1'b0;
    tick(1);
    rst = 1'b1; in_valid = 1'b0;
    tick(1);
    exp_q.delete();
    chk("mid_rst_send", {63'd0, send_out}, 64'd0);
    chk("mid_rst_credit", {61'd0, credit_count}, 64'd4);
    chk("mid_rst_active", {63'd0, pkt_active}, 64'd0);
    tick(1);
    rst = 1'b0;
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    tick(5);
    chk("mid_rst_sent2", 64'(sent_cnt - base), 64'd2);
    chk("mid_rst_credit_after", {61'd0, credit_count}, 64'd4);

    // Everything expected must have been seen.
    begin
      int w = 0;
      while (exp_q.size() != 0 && w < 100) begin
        @(posedge clk);
        w++;
      end
    end
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
